// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, memory-stage FSM states and the
// op-class decode used by the memory stage.
package cpu_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b01101;
  localparam logic [4:0] OP_STORE = 5'b01110;
  localparam logic [4:0] OP_PUSH  = 5'b01111;
  localparam logic [4:0] OP_POP   = 5'b10000;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_e;

  typedef enum logic [1:0] {
    OPC_NONMEM,
    OPC_LOAD,
    OPC_STORE
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    cls = OPC_NONMEM;
    if (op == OP_LOAD || op == OP_POP) cls = OPC_LOAD;
    else if (op == OP_STORE || op == OP_PUSH) cls = OPC_STORE;
    return cls;
  endfunction

  // NOP is the only non-memory op that leaves the register file untouched.
  function automatic logic writes_reg(input logic [4:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory stage: issues data-memory accesses for loads/stores, passes other
// results through, and presents a registered writeback bundle with backpressure.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] exeOut,
  input  logic [31:0] RegData1_o,
  input  logic [4:0]  opcode,
  input  logic [4:0]  wb_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_en,
  output logic        fault
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e       state, state_nxt;
  op_class_e        cls;
  logic [CNT_W-1:0] tmo_cnt;
  logic [4:0]       dst_q;
  logic             accept, misaligned, tmo_hit, start_access;
  logic             load_bundle, bundle_wen, bundle_fault;
  logic [31:0]      bundle_data;
  logic [4:0]       bundle_reg;

  assign cls          = op_class(opcode);
  assign in_ready     = (state == IDLE) && (!out_valid || out_ready);
  assign accept       = in_valid && in_ready;
  assign misaligned   = (exeOut[1:0] != 2'b00);
  assign start_access = accept && (cls != OPC_NONMEM) && !misaligned;
  assign tmo_hit      = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign dmem_req     = (state == ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // dmem_we doubles as the held op class while in ACCESS (1 = store).
  always_comb begin
    state_nxt    = state;
    load_bundle  = 1'b0;
    bundle_data  = exeOut;
    bundle_reg   = wb_reg_in;
    bundle_wen   = 1'b0;
    bundle_fault = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cls == OPC_NONMEM) begin
            load_bundle = 1'b1;
            bundle_wen  = writes_reg(opcode);
          end else if (misaligned) begin
            load_bundle  = 1'b1;
            bundle_fault = 1'b1;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        bundle_reg  = dst_q;
        bundle_data = dmem_addr;
        if (dmem_ack) begin
          load_bundle = 1'b1;
          state_nxt   = IDLE;
          bundle_wen  = !dmem_we;
          if (!dmem_we) bundle_data = dmem_rdata;
        end else if (tmo_hit) begin
          load_bundle  = 1'b1;
          bundle_fault = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dst_q      <= '0;
      tmo_cnt    <= '0;
    end else if (start_access) begin
      dmem_we    <= (cls == OPC_STORE);
      dmem_addr  <= exeOut;
      dmem_wdata <= RegData1_o;
      dst_q      <= wb_reg_in;
      tmo_cnt    <= '0;
    end else if (state == ACCESS) begin
      if (dmem_ack || tmo_hit) begin
        dmem_we <= 1'b0;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  // Writeback bundle: a new load always wins over the consume-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      wb_data   <= '0;
      wb_reg    <= '0;
      wb_en     <= 1'b0;
      fault     <= 1'b0;
    end else if (load_bundle) begin
      out_valid <= 1'b1;
      wb_data   <= bundle_data;
      wb_reg    <= bundle_reg;
      wb_en     <= bundle_wen;
      fault     <= bundle_fault;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// compared against a transaction-level reference model.
module tb_mem_stage;
  import cpu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] exeOut = '0;
  logic [31:0] RegData1_o = '0;
  logic [4:0]  opcode = '0;
  logic [4:0]  wb_reg_in = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_en, fault;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exeOut(exeOut), .RegData1_o(RegData1_o), .opcode(opcode), .wb_reg_in(wb_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic bit is_load_op(input logic [4:0] op);
    return op == OP_LOAD || op == OP_POP;
  endfunction

  function automatic bit is_store_op(input logic [4:0] op);
    return op == OP_STORE || op == OP_PUSH;
  endfunction

  // Transaction-level expectation: latency in cycles after acceptance, and the bundle.
  task automatic model_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rd,
                          input int lat, output int e_lat, output logic [31:0] e_data,
                          output logic e_wen, output logic e_fault);
    e_lat = 0; e_data = addr; e_wen = 1'b0; e_fault = 1'b0;
    if (!is_load_op(op) && !is_store_op(op)) begin
      e_wen = (op != OP_NOP);
    end else if (addr[1:0] != 2'b00) begin
      e_fault = 1'b1;
    end else if (lat >= 1 && lat <= TMO) begin
      e_lat = lat;
      if (is_load_op(op)) begin e_data = rd; e_wen = 1'b1; end
    end else begin
      e_lat = TMO;
      e_fault = 1'b1;
    end
  endtask

  // Drives one op with out_ready=1 and an ack on request cycle 'lat' (0 = never).
  task automatic do_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic [4:0] dest, input int lat,
                       output int o_lat, output int o_req, output logic [31:0] o_data,
                       output logic [4:0] o_reg, output logic o_wen, output logic o_fault,
                       output int o_bad);
    int guard;
    o_lat = 0; o_req = 0; o_bad = 0; o_data = '0; o_reg = '0; o_wen = 1'b0; o_fault = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; exeOut = addr; RegData1_o = wd; wb_reg_in = dest;
    out_ready = 1'b1; dmem_ack = 1'($urandom_range(0, 1));
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk); guard++; dmem_ack = 1'($urandom_range(0, 1));
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_wait: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0; dmem_ack = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0; exeOut = $urandom; RegData1_o = $urandom; opcode = 5'($urandom);
    wb_reg_in = 5'($urandom); dmem_ack = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      o_lat++;
      if (dmem_req) begin
        o_req++;
        if (dmem_addr !== addr || dmem_wdata !== wd || dmem_we !== 1'(is_store_op(op))) o_bad++;
        dmem_ack = (o_req == lat);
        dmem_rdata = (o_req == lat) ? rd : $urandom;
      end else begin
        dmem_ack = 1'b0;
      end
      @(negedge clk); guard++;
    end
    dmem_ack = 1'b0;
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL result_wait: out_valid stayed %b, required 1", out_valid);
    end
    if (dmem_req) o_bad++;
    o_data = wb_data; o_reg = wb_reg; o_wen = wb_en; o_fault = fault;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL reset_dmem: req=%b we=%b required 0 0", dmem_req, dmem_we); end
    checks++; if (out_valid !== 1'b0 || wb_en !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_bundle_ctl: valid=%b wen=%b fault=%b required 0 0 0", out_valid, wb_en, fault); end
    checks++; if (wb_data !== 32'h0 || wb_reg !== 5'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_data: wb_data=%h wb_reg=%h addr=%h wdata=%h required 0", wb_data, wb_reg, dmem_addr, dmem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_nonmem;
    int l, r, b; logic [31:0] d; logic [4:0] g; logic w, f;
    do_op(5'b00001, 32'h5, 32'h0, 32'h0, 5'd3, 0, l, r, d, g, w, f, b);
    checks++; if (l !== 0 || r !== 0) begin errors++; $display("FAIL nonmem_latency: lat=%0d req=%0d required 0 0", l, r); end
    checks++; if (d !== 32'h5 || g !== 5'd3 || w !== 1'b1 || f !== 1'b0) begin errors++; $display("FAIL nonmem_bundle: data=%h reg=%0d wen=%b fault=%b required 5 3 1 0", d, g, w, f); end
    do_op(OP_NOP, 32'h77, 32'h0, 32'h0, 5'd4, 0, l, r, d, g, w, f, b);
    checks++; if (w !== 1'b0 || d !== 32'h77) begin errors++; $display("FAIL nop_wen: wen=%b data=%h required 0 77", w, d); end
  endtask

  task automatic test_load;
    int l, r, b; logic [31:0] d; logic [4:0] g; logic w, f;
    do_op(OP_LOAD, 32'h100, 32'h1234, 32'hDEADBEEF, 5'd9, 3, l, r, d, g, w, f, b);
    checks++; if (r !== 3 || l !== 3 || b !== 0) begin errors++; $display("FAIL load_req: req_cycles=%0d lat=%0d bad=%0d required 3 3 0", r, l, b); end
    checks++; if (d !== 32'hDEADBEEF || w !== 1'b1 || f !== 1'b0 || g !== 5'd9) begin errors++; $display("FAIL load_bundle: data=%h wen=%b fault=%b reg=%0d required deadbeef 1 0 9", d, w, f, g); end
  endtask

  task automatic test_misaligned;
    int l, r, b; logic [31:0] d; logic [4:0] g; logic w, f;
    do_op(OP_STORE, 32'h102, 32'hAAAA, 32'h0, 5'd2, 1, l, r, d, g, w, f, b);
    checks++; if (r !== 0 || l !== 0) begin errors++; $display("FAIL misaligned_req: req_cycles=%0d lat=%0d required 0 0", r, l); end
    checks++; if (f !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL misaligned_bundle: fault=%b wen=%b required 1 0", f, w); end
  endtask

  task automatic test_timeout;
    int l, r, b; logic [31:0] d; logic [4:0] g; logic w, f;
    do_op(OP_LOAD, 32'h200, 32'h0, 32'h0, 5'd5, 0, l, r, d, g, w, f, b);
    checks++; if (r !== TMO || b !== 0) begin errors++; $display("FAIL timeout_req: req_cycles=%0d bad=%0d required %0d 0", r, b, TMO); end
    checks++; if (f !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL timeout_bundle: fault=%b wen=%b required 1 0", f, w); end
    do_op(OP_PUSH, 32'h204, 32'h55, 32'h0, 5'd6, TMO, l, r, d, g, w, f, b);
    checks++; if (r !== TMO || f !== 1'b0 || w !== 1'b0 || d !== 32'h204) begin errors++; $display("FAIL ack_at_timeout: req=%0d fault=%b wen=%b data=%h required %0d 0 0 204", r, f, w, d, TMO); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    in_valid = 1'b1; opcode = 5'b00010; exeOut = 32'hA1; wb_reg_in = 5'd7; out_ready = 1'b0;
    @(negedge clk);
    opcode = 5'b00011; exeOut = 32'hB2; wb_reg_in = 5'd9;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || wb_data !== 32'hA1 || wb_reg !== 5'd7 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: valid=%b data=%h reg=%0d in_ready=%b required 1 a1 7 0", i, out_valid, wb_data, wb_reg, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || wb_data !== 32'hB2 || wb_reg !== 5'd9) begin errors++; $display("FAIL bp_next: valid=%b data=%h reg=%0d required 1 b2 9", out_valid, wb_data, wb_reg); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_clear: valid=%b required 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, in_ready); end
      in_valid = 1'b1; opcode = 5'b00100; exeOut = v; wb_reg_in = 5'(i);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || wb_data !== v || wb_reg !== 5'(i)) begin errors++; $display("FAIL b2b_data[%0d]: valid=%b data=%h required 1 %h", i, out_valid, wb_data, v); end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    in_valid = 1'b1; opcode = OP_LOAD; exeOut = 32'h300; wb_reg_in = 5'd1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: dmem_req=%b required 1", dmem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_now: req=%b valid=%b we=%b required 0 0 0", dmem_req, out_valid, dmem_we); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || dmem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after[%0d]: in_ready=%b req=%b valid=%b required 1 0 0", i, in_ready, dmem_req, out_valid); end
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_random;
    int l, r, b, el; logic [31:0] d, ed, addr, wd, rd; logic [4:0] g, op, dest; logic w, f, ew, ef;
    int lat;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: op = OP_LOAD;
        1: op = OP_STORE;
        2: op = OP_PUSH;
        3: op = OP_POP;
        4: op = OP_NOP;
        default: begin
          op = 5'($urandom);
          while (is_load_op(op) || is_store_op(op)) op = 5'($urandom);
        end
      endcase
      addr = $urandom;
      if ($urandom_range(0, 9) < 7) addr[1:0] = 2'b00;
      wd = $urandom; rd = $urandom; dest = 5'($urandom);
      lat = $urandom_range(0, TMO + 1);
      model_op(op, addr, rd, lat, el, ed, ew, ef);
      do_op(op, addr, wd, rd, dest, lat, l, r, d, g, w, f, b);
      checks++; if (l !== el || r !== el || b !== 0) begin errors++; $display("FAIL rand_timing[%0d] op=%h: lat=%0d req=%0d bad=%0d required %0d %0d 0", n, op, l, r, b, el, el); end
      checks++; if (d !== ed || g !== dest) begin errors++; $display("FAIL rand_data[%0d] op=%h: data=%h reg=%0d required %h %0d", n, op, d, g, ed, dest); end
      checks++; if (w !== ew || f !== ef) begin errors++; $display("FAIL rand_flags[%0d] op=%h: wen=%b fault=%b required %b %b", n, op, w, f, ew, ef); end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_misaligned();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
